pipo_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `pipo` latch, and the output bus it drives, among N requesters. It picks one pending requester and latches that requester's data into the `pipo` with a one-cycle `le` pulse. It then enables the `pipo` output (`oe_n` low) for a fixed hold window and inserts a one-cycle bus turnaround before serving the next requester. It sits between the requesting blocks and the `pipo` instance, whose `in`, `le` and `oe_n` pins it drives directly.

---
 rtl/pipo_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_pipo_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipo_bus_arbiter.sv
// ---------------------------------------------------------------------------
// pipo_bus_arbiter
//
// Round-robin arbiter and sequencer sharing one pipo latch (and the bus it
// drives) among N requesters. A grant latches the winner's data slice, pulses
// le for one cycle, holds oe_n low for HOLD cycles, then spends one turnaround
// cycle with oe_n high while pulsing the winner's ack bit.
//
// Handshake: req[i] is a level sampled only while idle. Once granted, the
// transfer always runs to completion (unless rst) and ends with a one-cycle
// ack[i] pulse. A requester still holding req after its ack is treated as a
// new request, with lowest priority because the pointer has moved past it.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   req         [N]         request levels, bit i = requester i
//   req_data    [N*WIDTH]   requester i data at [i*WIDTH +: WIDTH]
//   ack         [N]         one-hot completion pulse
//   latch_data  [WIDTH]     to pipo.in (registered)
//   le          to pipo.le (registered)
//   oe_n        to pipo.oe_n, active low (registered)
//   owner       [$clog2(N)] requester currently being served
//   busy        high in any state other than IDLE
//   fsm_state   [2]         debug view of the FSM state (0=IDLE,1=LATCH,
//                           2=DRIVE,3=TURN)
// ---------------------------------------------------------------------------
module pipo_bus_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int HOLD  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N-1:0]                   req,
  input  logic [N*WIDTH-1:0]             req_data,
  output logic [N-1:0]                   ack,
  output logic [WIDTH-1:0]               latch_data,
  output logic                           le,
  output logic                           oe_n,
  output logic [((N>1)?$clog2(N):1)-1:0] owner,
  output logic                           busy,
  output logic [1:0]                     fsm_state
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_DRIVE = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t          state;
  logic [OW-1:0]   rr_ptr;
  logic [CW-1:0]   hold_cnt;

  assign fsm_state = state;

  // -------------------------------------------------------------------------
  // Round-robin winner search.
  // Rotating a doubled copy of req right by rr_ptr puts requester
  // (rr_ptr + k) mod N at bit k, so the first set bit from the bottom is the
  // winner's offset from the pointer.
  // -------------------------------------------------------------------------
  logic [2*N-1:0]  req_dbl;
  logic [N-1:0]    req_rot;
  logic [OW-1:0]   win_off;
  logic            win_found;
  logic [OW:0]     win_sum;
  logic [OW-1:0]   win_idx;
  logic [WIDTH-1:0] win_data;

  assign req_dbl = {req, req} >> rr_ptr;
  assign req_rot = req_dbl[N-1:0];

  always_comb begin
    win_off   = '0;
    win_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_off   = OW'(k);
      end
    end
  end

  // Modulo-N add of pointer and offset; both are < N so one subtract suffices.
  always_comb begin
    win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    if (win_sum >= (OW+1)'(N)) begin
      win_sum = win_sum - (OW+1)'(N);
    end
    win_idx = win_sum[OW-1:0];
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == OW'(i)) begin
        win_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer value after serving the current owner: (owner + 1) mod N.
  logic [OW-1:0] next_ptr;
  always_comb begin
    if (owner == OW'(N - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = owner + 1'b1;
    end
  end

  logic [N-1:0] owner_onehot;
  assign owner_onehot = {{(N-1){1'b0}}, 1'b1} << owner;

  // -------------------------------------------------------------------------
  // Sequencer FSM. All outputs are registered here, so le and the low phase
  // of oe_n come from mutually exclusive states and can never overlap.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      latch_data <= '0;
      le         <= 1'b0;
      oe_n       <= 1'b1;
      ack        <= '0;
      busy       <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            owner      <= win_idx;
            latch_data <= win_data;
            le         <= 1'b1;
            busy       <= 1'b1;
            state      <= S_LATCH;
          end
        end
        S_LATCH: begin
          le       <= 1'b0;
          oe_n     <= 1'b0;
          hold_cnt <= '0;
          state    <= S_DRIVE;
        end
        S_DRIVE: begin
          if (hold_cnt == CW'(HOLD - 1)) begin
            oe_n     <= 1'b1;
            ack      <= owner_onehot;
            rr_ptr   <= next_ptr;
            hold_cnt <= '0;
            state    <= S_TURN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_TURN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipo_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pipo_bus_arbiter
//
// Directed scenarios drive req/req_data and push the hand-computed expected
// transfers {owner, data} into exp_q. An independent monitor pops one entry
// per le pulse and checks the grant, the drive window (through a behavioural
// pipo model), the ack pulse, its latency and spacing, and the invariants.
// ---------------------------------------------------------------------------
module tb_pipo_bus_arbiter;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int HOLD  = 4;
  localparam int OW    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               rst_q = 1'b1;
  int                 cyc   = 0;
  always @(posedge clk) begin
    rst_q <= rst;
    cyc   <= cyc + 1;
  end

  // ---------------- DUT ----------------
  logic [N-1:0]       req      = '0;
  logic [N*WIDTH-1:0] req_data = '0;
  logic [N-1:0]       ack;
  logic [WIDTH-1:0]   latch_data;
  logic               le;
  logic               oe_n;
  logic [OW-1:0]      owner;
  logic               busy;
  logic [1:0]         fsm_state;

  pipo_bus_arbiter #(.WIDTH(WIDTH), .N(N), .HOLD(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .latch_data (latch_data),
    .le         (le),
    .oe_n       (oe_n),
    .owner      (owner),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // Behavioural pipo: captures in while le is high, drives out when oe_n low.
  logic [WIDTH-1:0] pipo_q = '0;
  logic [WIDTH-1:0] pipo_out;
  always @(posedge clk) if (le) pipo_q <= latch_data;
  assign pipo_out = oe_n ? 'z : pipo_q;

  // ---------------- scoreboard ----------------
  logic [OW+WIDTH-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int scn    = 0;
  bit gap_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit                  cur_v;
    int                  cur_idx;
    logic [WIDTH-1:0]    cur_d;
    int                  drive_run;
    bit                  prev_ack;
    int                  le_cyc;
    int                  last_ack_cyc;
    int                  last_ack_scn;
    logic [OW+WIDTH-1:0] e;
    cur_v = 0; cur_idx = 0; cur_d = '0; drive_run = 0; prev_ack = 0;
    le_cyc = 0; last_ack_cyc = 0; last_ack_scn = -1;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        cur_v = 0; drive_run = 0; prev_ack = 0; last_ack_scn = -1;
        continue;
      end
      chk("le_oe_overlap", {31'd0, le & ~oe_n}, 32'd0);
      chk("ack_onehot0", {31'd0, $onehot0(ack)}, 32'd1);
      if (le) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_grant: owner %0d data %0h, no transfer expected", owner, latch_data);
        end else begin
          e = exp_q.pop_front();
          chk("grant_owner", {30'd0, owner}, {30'd0, e[WIDTH +: OW]});
          chk("grant_data", {24'd0, latch_data}, {24'd0, e[WIDTH-1:0]});
        end
        chk("busy_in_latch", {31'd0, busy}, 32'd1);
        cur_v = 1; cur_idx = int'(owner); cur_d = latch_data; le_cyc = cyc;
      end
      if (!oe_n) begin
        drive_run++;
        chk("pipo_out_in_drive", {24'd0, pipo_out}, {24'd0, cur_d});
        chk("latch_data_stable", {24'd0, latch_data}, {24'd0, cur_d});
        if (drive_run > HOLD) chk("drive_overrun", drive_run, HOLD);
      end else if (drive_run > 0) begin
        chk("drive_len", drive_run, HOLD);
        drive_run = 0;
      end
      if (ack != '0) begin
        chk("ack_has_xfer", {31'd0, cur_v}, 32'd1);
        chk("ack_owner", {28'd0, ack}, 32'd1 << cur_idx);
        chk("ack_latency", cyc - le_cyc, HOLD + 1);
        chk("busy_in_turn", {31'd0, busy}, 32'd1);
        if (gap_en && last_ack_scn == scn) chk("ack_gap", cyc - last_ack_cyc, HOLD + 3);
        last_ack_cyc = cyc; last_ack_scn = scn;
        cur_v = 0; prev_ack = 1;
      end else if (prev_ack) begin
        chk("idle_after_turn_busy", {31'd0, busy}, 32'd0);
        chk("idle_after_turn_state", {30'd0, fsm_state}, 32'd0);
        prev_ack = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_slice(input int i, input logic [WIDTH-1:0] v);
    req_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic push_exp(input int i, input logic [WIDTH-1:0] v);
    logic [OW-1:0] idx;
    idx = OW'(i);
    exp_q.push_back({idx, v});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_le();
    int t;
    t = 0;
    while (t < 50) begin
      @(negedge clk);
      if (le) return;
      t++;
    end
    n_cmp++; n_fail++;
    $display("FAIL wait_le_timeout: got no le pulse within 50 cycles, required one");
  endtask

  task automatic wait_acks(input int n);
    int got;
    int t;
    got = 0; t = 0;
    while (got < n && t < 200) begin
      @(negedge clk);
      if (ack != '0) got++;
      t++;
    end
    if (got < n) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_acks_timeout: got %0d acks, required %0d", got, n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_latch_data", {24'd0, latch_data}, 32'd0);
    chk("rst_le", {31'd0, le}, 32'd0);
    chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_state", {30'd0, fsm_state}, 32'd0);
    rst = 1'b0;

    // Single request from requester 2.
    scn = 1;
    set_slice(2, 8'h55);
    push_exp(2, 8'h55);
    req = 4'b0100;
    wait_acks(1);
    req = '0;
    repeat (3) @(negedge clk);
    do_reset();

    // Two requesters held after reset: 1, 3, 1.
    scn = 2;
    set_slice(1, 8'hAA);
    set_slice(3, 8'h0F);
    push_exp(1, 8'hAA);
    push_exp(3, 8'h0F);
    push_exp(1, 8'hAA);
    req = 4'b1010;
    wait_acks(3);
    req = '0;
    repeat (3) @(negedge clk);
    do_reset();

    // Full load: 0,1,2,3 twice, acks 7 cycles apart.
    scn = 3;
    gap_en = 1'b1;
    set_slice(0, 8'h11);
    set_slice(1, 8'h22);
    set_slice(2, 8'h33);
    set_slice(3, 8'h44);
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 8'h11);
      push_exp(1, 8'h22);
      push_exp(2, 8'h33);
      push_exp(3, 8'h44);
    end
    req = 4'b1111;
    wait_acks(8);
    req = '0;
    repeat (3) @(negedge clk);
    gap_en = 1'b0;

    // Requester 0 drops req and changes data during DRIVE.
    scn = 4;
    set_slice(0, 8'h3C);
    push_exp(0, 8'h3C);
    req = 4'b0001;
    wait_le();
    @(negedge clk);
    @(negedge clk);
    req = '0;
    set_slice(0, 8'hC3);
    wait_acks(1);
    repeat (4) @(negedge clk);

    // Reset in the 2nd DRIVE cycle; pointer is 1 here, so requester 1 wins
    // first, and after reset the pointer is 0 so requester 0 wins.
    scn = 5;
    set_slice(0, 8'h5A);
    set_slice(1, 8'hA5);
    push_exp(1, 8'hA5);
    req = 4'b0011;
    wait_le();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_oe_n", {31'd0, oe_n}, 32'd1);
    chk("abort_le", {31'd0, le}, 32'd0);
    chk("abort_ack", {28'd0, ack}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    push_exp(0, 8'h5A);
    wait_acks(1);
    req = '0;
    repeat (5) @(negedge clk);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
